rom_bus_arbiter: RTL

- Owns the game-pak ROM bus (rom_a/rom_d) and shares it between three requesters: SNES host reads, GSU instruction-cache fetches, and GSU ROM-buffer reads (ROMBR:R14 prefetch).
- Sequences each access with a programmable wait count.
- Sits between the pins and the instruction-fetch and ROM-buffer logic of the core.
- Enforces the RON ownership bit: when the GSU owns ROM, host reads get a fixed dummy byte.

---
 rtl/rom_bus_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter: owns the game-pak ROM bus and shares it between SNES host reads,
// GSU instruction-cache fetches and GSU ROM-buffer reads.
//
// Ports:
//   clk_i, rst_ni            core clock, asynchronous active-low reset
//   ron_i                    1 = GSU owns ROM, 0 = host owns ROM
//   host_rd_i/host_a_i       host read request (level) and address
//   host_d_o/host_rdy_o      host read data and one-cycle valid pulse
//   fetch_req_i/fetch_a_i    cache fetch request (held until rdy) and address
//   fetch_d_o/fetch_rdy_o    fetch data and one-cycle valid pulse
//   buf_req_i/buf_a_i        ROM-buffer request (held until rdy) and address
//   buf_d_o/buf_rdy_o        buffer data and one-cycle valid pulse
//   rom_a_o/rom_d_i          registered ROM address, ROM data
//   busy_o                   high while an access is in flight
module rom_bus_arbiter #(
    parameter int unsigned ROM_WAIT   = 4,
    parameter logic [7:0]  HOST_DUMMY = 8'h01
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ron_i,
    input  logic        host_rd_i,
    input  logic [23:0] host_a_i,
    output logic [7:0]  host_d_o,
    output logic        host_rdy_o,
    input  logic        fetch_req_i,
    input  logic [23:0] fetch_a_i,
    output logic [7:0]  fetch_d_o,
    output logic        fetch_rdy_o,
    input  logic        buf_req_i,
    input  logic [23:0] buf_a_i,
    output logic [7:0]  buf_d_o,
    output logic        buf_rdy_o,
    output logic [23:0] rom_a_o,
    input  logic [7:0]  rom_d_i,
    output logic        busy_o
);

    localparam int unsigned CntW = (ROM_WAIT > 1) ? $clog2(ROM_WAIT) : 1;
    localparam logic GsuFetch = 1'b0;
    localparam logic GsuBuf   = 1'b1;

    typedef enum logic {StIdle, StAccess} state_e;
    typedef enum logic [1:0] {GntHost, GntFetch, GntBuf} gnt_e;

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_gsu_q, last_gsu_d;
    logic [23:0]       rom_a_q, rom_a_d;
    logic [7:0]        host_d_q, host_d_d, fetch_d_q, fetch_d_d, buf_d_q, buf_d_d;
    logic              host_rdy_q, host_rdy_d, fetch_rdy_q, fetch_rdy_d, buf_rdy_q, buf_rdy_d;
    logic              take_host, take_fetch, take_buf;
    logic              host_in_flight;

    always_comb begin
        take_host  = 1'b0;
        take_fetch = 1'b0;
        take_buf   = 1'b0;
        if (state_q == StIdle) begin
            if (!ron_i) begin
                take_host = host_rd_i;
            end else if (fetch_req_i && buf_req_i) begin
                // Round-robin: grant whichever GSU requester was not served last.
                take_fetch = (last_gsu_q == GsuBuf);
                take_buf   = (last_gsu_q == GsuFetch);
            end else begin
                take_fetch = fetch_req_i;
                take_buf   = buf_req_i;
            end
        end
    end

    assign host_in_flight = (state_q == StAccess) && (gnt_q == GntHost);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        last_gsu_d  = last_gsu_q;
        rom_a_d     = rom_a_q;
        host_d_d    = host_d_q;
        fetch_d_d   = fetch_d_q;
        buf_d_d     = buf_d_q;
        host_rdy_d  = 1'b0;
        fetch_rdy_d = 1'b0;
        buf_rdy_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (take_host || take_fetch || take_buf) begin
                    state_d = StAccess;
                    cnt_d   = CntW'(ROM_WAIT - 1);
                    if (take_host) begin
                        gnt_d   = GntHost;
                        rom_a_d = host_a_i;
                    end else if (take_fetch) begin
                        gnt_d      = GntFetch;
                        rom_a_d    = fetch_a_i;
                        last_gsu_d = GsuFetch;
                    end else begin
                        gnt_d      = GntBuf;
                        rom_a_d    = buf_a_i;
                        last_gsu_d = GsuBuf;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    unique case (gnt_q)
                        GntHost: begin
                            host_d_d   = rom_d_i;
                            host_rdy_d = 1'b1;
                        end
                        GntFetch: begin
                            fetch_d_d   = rom_d_i;
                            fetch_rdy_d = 1'b1;
                        end
                        GntBuf: begin
                            buf_d_d   = rom_d_i;
                            buf_rdy_d = 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Host locked out while GSU owns ROM: answer with a dummy byte, never touching the bus.
        // Suppressed while a real host access drains so host_rdy never doubles up.
        if (ron_i && host_rd_i && !host_rdy_q && !host_in_flight) begin
            host_d_d   = HOST_DUMMY;
            host_rdy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            gnt_q       <= GntHost;
            cnt_q       <= '0;
            last_gsu_q  <= GsuBuf;
            rom_a_q     <= '0;
            host_d_q    <= '0;
            fetch_d_q   <= '0;
            buf_d_q     <= '0;
            host_rdy_q  <= 1'b0;
            fetch_rdy_q <= 1'b0;
            buf_rdy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            last_gsu_q  <= last_gsu_d;
            rom_a_q     <= rom_a_d;
            host_d_q    <= host_d_d;
            fetch_d_q   <= fetch_d_d;
            buf_d_q     <= buf_d_d;
            host_rdy_q  <= host_rdy_d;
            fetch_rdy_q <= fetch_rdy_d;
            buf_rdy_q   <= buf_rdy_d;
        end
    end

    assign rom_a_o     = rom_a_q;
    assign host_d_o    = host_d_q;
    assign fetch_d_o   = fetch_d_q;
    assign buf_d_o     = buf_d_q;
    assign host_rdy_o  = host_rdy_q;
    assign fetch_rdy_o = fetch_rdy_q;
    assign buf_rdy_o   = buf_rdy_q;
    assign busy_o      = (state_q == StAccess);

endmodule
